// File: rtl/pipe_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg_pkg
//   Shared pipeline definitions for the 5-stage core. Holds the ID/EX control
//   and payload structs that the ID/EX stage register carries, plus their
//   widths. The all-zero control word is the bubble encoding: it decodes to
//   no register write, no memory access, no branch/jump, WB_NONE and an ADD
//   whose result is never written back.
// ---------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    // Write-back source select; 0 must mean "nothing written back".
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PC4  = 2'd3
    } wb_sel_e;

    // ALU operation; 0 is ADD, which is harmless in a bubble.
    typedef enum logic [3:0] {
        ALUOP_ADD  = 4'd0,
        ALUOP_SUB  = 4'd1,
        ALUOP_AND  = 4'd2,
        ALUOP_OR   = 4'd3,
        ALUOP_XOR  = 4'd4,
        ALUOP_SLL  = 4'd5,
        ALUOP_SRL  = 4'd6,
        ALUOP_SRA  = 4'd7,
        ALUOP_SLT  = 4'd8,
        ALUOP_SLTU = 4'd9,
        ALUOP_LUI  = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_write;
        logic    mem_read;
        logic    branch;
        logic    jump;
        wb_sel_e wb_sel;
        alu_op_e alu_op;
        logic    alu_src1;
        logic    alu_src2;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] instr;
    } id_ex_data_t;

    localparam int ID_EX_CTRL_W = $bits(id_ex_ctrl_t);
    localparam int ID_EX_DATA_W = $bits(id_ex_data_t);

endpackage

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Valid/ready pipeline-stage register carrying a payload and a control
//   field between two core stages. Supports back-pressure, an optional
//   2-entry skid (SKID_EN=1) giving full throughput with in_ready driven
//   from state only, and a synchronous flush that turns held beats into
//   bubbles. The control field of any invalid entry is held at 0.
//
// Parameters
//   DATA_W   payload width
//   CTRL_W   control-field width
//   SKID_EN  1: main + skid entry, in_ready = !s_valid
//            0: single entry, in_ready = out_ready | !m_valid
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   flush                drop every held entry (redirect)
//   in_valid/in_ready    upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready  downstream handshake, out_data/out_ctrl payload
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W  = 160,
    parameter int CTRL_W  = 16,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    // Main entry drives the outputs; skid entry only ever loads when SKID_EN=1.
    logic              m_valid, m_valid_d;
    logic [DATA_W-1:0] m_data,  m_data_d;
    logic [CTRL_W-1:0] m_ctrl,  m_ctrl_d;
    logic              s_valid, s_valid_d;
    logic [DATA_W-1:0] s_data,  s_data_d;
    logic [CTRL_W-1:0] s_ctrl,  s_ctrl_d;

    logic in_fire;
    logic out_fire;

    // rst_n gating keeps in_ready low during reset and lets it rise in the
    // first cycle after release without waiting for an extra edge.
    always_comb begin
        if (SKID_EN)
            in_ready = rst_n & ~s_valid;
        else
            in_ready = rst_n & (out_ready | ~m_valid);
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid & out_ready;

    always_comb begin
        m_valid_d = m_valid;
        m_data_d  = m_data;
        m_ctrl_d  = m_ctrl;
        s_valid_d = s_valid;
        s_data_d  = s_data;
        s_ctrl_d  = s_ctrl;

        if (SKID_EN) begin
            if (out_fire) begin
                if (s_valid) begin
                    // in_ready is low while skid is full, so no input fire here.
                    m_valid_d = 1'b1;
                    m_data_d  = s_data;
                    m_ctrl_d  = s_ctrl;
                    s_valid_d = 1'b0;
                    s_ctrl_d  = '0;
                end else if (in_fire) begin
                    m_valid_d = 1'b1;
                    m_data_d  = in_data;
                    m_ctrl_d  = in_ctrl;
                end else begin
                    m_valid_d = 1'b0;
                    m_ctrl_d  = '0;
                end
            end else if (in_fire) begin
                if (!m_valid) begin
                    m_valid_d = 1'b1;
                    m_data_d  = in_data;
                    m_ctrl_d  = in_ctrl;
                end else begin
                    s_valid_d = 1'b1;
                    s_data_d  = in_data;
                    s_ctrl_d  = in_ctrl;
                end
            end
        end else begin
            if (in_fire) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
                m_ctrl_d  = in_ctrl;
            end else if (out_fire) begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
            end
        end

        // Flush wins over any transfer; a beat accepted this cycle is lost.
        if (flush) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_valid_d = 1'b0;
            s_ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= '0;
        end else begin
            m_valid <= m_valid_d;
            m_data  <= m_data_d;
            m_ctrl  <= m_ctrl_d;
            s_valid <= s_valid_d;
            s_data  <= s_data_d;
            s_ctrl  <= s_ctrl_d;
        end
    end

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl;

endmodule
